// File: rtl/glm_load_pkg.sv
// ---------------------------------------------------------------------------
// glm_common: shared types and constants for the GLM load engine.
//   t_loadstate       : load FSM state encoding
//   LOAD_REG_*        : index of each field inside the 7-word instruction
//   ADDR_SELECT_BIT   : bit of the address register choosing in/out region
//   widths            : cache-line address, line, counter and select widths
// ---------------------------------------------------------------------------
package glm_common;

    typedef enum logic [1:0] {
        LS_IDLE       = 2'd0,
        LS_PREPROCESS = 2'd1,
        LS_READ       = 2'd2,
        LS_DONE       = 2'd3
    } t_loadstate;

    localparam int LOAD_NUM_REGS    = 7;
    localparam int LOAD_REG_OFFSET0 = 0;
    localparam int LOAD_REG_OFFSET1 = 1;
    localparam int LOAD_REG_OFFSET2 = 2;
    localparam int LOAD_REG_ADDR    = 3;
    localparam int LOAD_REG_LEN     = 4;
    localparam int LOAD_REG_SEL     = 5;
    localparam int LOAD_REG_WBASE   = 6;

    localparam int ADDR_SELECT_BIT  = 31;

    localparam int CL_ADDR_W = 42;
    localparam int LINE_W    = 512;
    localparam int CNT_W     = 16;
    localparam int SEL_W     = 4;

endpackage

// File: rtl/glm_load_wrdemux.sv
// ---------------------------------------------------------------------------
// glm_load_wrdemux: registered response-to-BRAM write stage, 1-cycle latency.
//   clk, reset            : clock, synchronous active-high reset
//   wr_valid              : accepted read response this cycle
//   wr_sel                : target BRAM channel; values >= NUM_CHANNELS
//                           produce no write enable at all
//   wr_addr, wr_data      : BRAM address (already offset) and line data
//   mem_we                : one-hot write enable, registered
//   mem_waddr, mem_wdata  : registered address / data
// ---------------------------------------------------------------------------
module glm_load_wrdemux
    import glm_common::*;
#(
    parameter int NUM_CHANNELS = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_valid,
    input  logic [SEL_W-1:0]        wr_sel,
    input  logic [CNT_W-1:0]        wr_addr,
    input  logic [LINE_W-1:0]       wr_data,
    output logic [NUM_CHANNELS-1:0] mem_we,
    output logic [CNT_W-1:0]        mem_waddr,
    output logic [LINE_W-1:0]       mem_wdata
);

    logic [NUM_CHANNELS-1:0] we_q, we_d;
    logic [CNT_W-1:0]        waddr_q, waddr_d;
    logic [LINE_W-1:0]       wdata_q, wdata_d;

    always_comb begin
        we_d    = '0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (wr_valid && (wr_sel == SEL_W'(i))) begin
                we_d[i] = 1'b1;
            end
        end
        // Address/data only move on an accepted response so the bus is quiet
        // between writes.
        if (wr_valid) begin
            waddr_d = wr_addr;
            wdata_d = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_waddr = waddr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: rtl/glm_load.sv
// ---------------------------------------------------------------------------
// glm_load: DRAM-to-BRAM load engine.
// Reads a contiguous range of cache lines over CCI-P channel 0 and writes
// each returned line into one selected BRAM channel.
//
// Handshake: c0_tx_valid is a one-cycle request strobe (never held); the
// producer guarantees acceptance unless c0TxAlmFull was high in the cycle the
// request was decided. c0_rsp_valid is a one-cycle response strobe that is
// always consumed while in READ and dropped in every other state.
//
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   op_start / op_done       : start strobe (IDLE only) / completion pulse
//   regs[7]                  : instruction words, latched on accepted start
//   in_addr, out_addr        : region base cache-line addresses
//   c0TxAlmFull              : request back-pressure
//   c0_tx_valid/addr/mdata   : registered read request, tag = line index
//   c0_rsp_valid/mdata/data  : read response
//   mem_we/waddr/wdata       : registered one-hot BRAM write port
//   dbg_state                : current FSM state for observation
//
// Build option: define GLM_LOAD_LIMIT_EN to cap in-flight requests at
// MAX_OUTSTANDING; otherwise only c0TxAlmFull throttles issue.
// ---------------------------------------------------------------------------
module glm_load
    import glm_common::*;
#(
    parameter int NUM_CHANNELS    = 2,
    parameter int MAX_OUTSTANDING = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    op_start,
    output logic                    op_done,
    input  logic [31:0]             regs [LOAD_NUM_REGS],
    input  logic [CL_ADDR_W-1:0]    in_addr,
    input  logic [CL_ADDR_W-1:0]    out_addr,
    input  logic                    c0TxAlmFull,
    output logic                    c0_tx_valid,
    output logic [CL_ADDR_W-1:0]    c0_tx_addr,
    output logic [15:0]             c0_tx_mdata,
    input  logic                    c0_rsp_valid,
    input  logic [15:0]             c0_rsp_mdata,
    input  logic [LINE_W-1:0]       c0_rsp_data,
    output logic [NUM_CHANNELS-1:0] mem_we,
    output logic [15:0]             mem_waddr,
    output logic [LINE_W-1:0]       mem_wdata,
    output t_loadstate              dbg_state
);

    t_loadstate            state_q, state_d;
    logic [CL_ADDR_W-1:0]  base_q, base_d;
    logic [31:0]           offset_q [3];
    logic [31:0]           offset_d [3];
    logic [CNT_W-1:0]      len_q, len_d;
    logic [CNT_W-1:0]      wbase_q, wbase_d;
    logic [CNT_W-1:0]      sent_q, sent_d;
    logic [CNT_W-1:0]      rcvd_q, rcvd_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [1:0]            pre_cnt_q, pre_cnt_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [CL_ADDR_W-1:0]  tx_addr_q, tx_addr_d;
    logic [15:0]           tx_mdata_q, tx_mdata_d;
    logic                  op_done_q, op_done_d;

    logic                  limit_ok;
    logic                  can_issue;
    logic                  rsp_take;
    logic [CL_ADDR_W-1:0]  start_base;

`ifdef GLM_LOAD_LIMIT_EN
    logic [CNT_W-1:0] outstanding;
    // sent never trails rcvd because every accepted tag was issued first.
    assign outstanding = sent_q - rcvd_q;
    assign limit_ok    = (outstanding < CNT_W'(MAX_OUTSTANDING));
`else
    logic unused_max_outstanding;
    assign limit_ok               = 1'b1;
    assign unused_max_outstanding = (MAX_OUTSTANDING != 0);
`endif

    // Only the low halves of the length/select/wbase words carry meaning.
    logic unused_regs;
    assign unused_regs = ^{regs[LOAD_REG_LEN][31:16],
                           regs[LOAD_REG_SEL][31:4],
                           regs[LOAD_REG_WBASE][31:16]};

    assign start_base = (regs[LOAD_REG_ADDR][ADDR_SELECT_BIT] ? in_addr : out_addr)
                      + {11'b0, regs[LOAD_REG_ADDR][30:0]};

    assign can_issue = (state_q == LS_READ) && (sent_q < len_q)
                    && !c0TxAlmFull && limit_ok;
    assign rsp_take  = (state_q == LS_READ) && c0_rsp_valid;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        offset_d   = offset_q;
        len_d      = len_q;
        wbase_d    = wbase_q;
        sent_d     = sent_q;
        rcvd_d     = rcvd_q;
        sel_d      = sel_q;
        pre_cnt_d  = pre_cnt_q;
        tx_valid_d = 1'b0;
        tx_addr_d  = tx_addr_q;
        tx_mdata_d = tx_mdata_q;
        op_done_d  = (state_q == LS_DONE);

        case (state_q)
            LS_IDLE: begin
                if (op_start) begin
                    base_d      = start_base;
                    offset_d[0] = regs[LOAD_REG_OFFSET0];
                    offset_d[1] = regs[LOAD_REG_OFFSET1];
                    offset_d[2] = regs[LOAD_REG_OFFSET2];
                    len_d       = regs[LOAD_REG_LEN][15:0];
                    sel_d       = regs[LOAD_REG_SEL][3:0];
                    wbase_d     = regs[LOAD_REG_WBASE][15:0];
                    sent_d      = '0;
                    rcvd_d      = '0;
                    pre_cnt_d   = '0;
                    state_d     = (regs[LOAD_REG_LEN][15:0] == '0) ? LS_DONE : LS_PREPROCESS;
                end
            end

            LS_PREPROCESS: begin
                // One offset folded in per cycle, k = 0, 1, 2.
                base_d    = base_q + {10'b0, offset_q[pre_cnt_q]};
                pre_cnt_d = pre_cnt_q + 2'd1;
                if (pre_cnt_q == 2'd2) begin
                    state_d = LS_READ;
                end
            end

            LS_READ: begin
                if (can_issue) begin
                    tx_valid_d = 1'b1;
                    tx_addr_d  = base_q + {26'b0, sent_q};
                    tx_mdata_d = sent_q;
                    sent_d     = sent_q + 16'd1;
                end
                if (rsp_take) begin
                    rcvd_d = rcvd_q + 16'd1;
                    if (rcvd_q == len_q - 16'd1) begin
                        state_d = LS_DONE;
                    end
                end
            end

            LS_DONE: begin
                state_d = LS_IDLE;
            end

            default: begin
                state_d = LS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= LS_IDLE;
            base_q     <= '0;
            for (int i = 0; i < 3; i++) begin
                offset_q[i] <= '0;
            end
            len_q      <= '0;
            wbase_q    <= '0;
            sent_q     <= '0;
            rcvd_q     <= '0;
            sel_q      <= '0;
            pre_cnt_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_addr_q  <= '0;
            tx_mdata_q <= '0;
            op_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            offset_q   <= offset_d;
            len_q      <= len_d;
            wbase_q    <= wbase_d;
            sent_q     <= sent_d;
            rcvd_q     <= rcvd_d;
            sel_q      <= sel_d;
            pre_cnt_q  <= pre_cnt_d;
            tx_valid_q <= tx_valid_d;
            tx_addr_q  <= tx_addr_d;
            tx_mdata_q <= tx_mdata_d;
            op_done_q  <= op_done_d;
        end
    end

    glm_load_wrdemux #(
        .NUM_CHANNELS (NUM_CHANNELS)
    ) u_wrdemux (
        .clk       (clk),
        .reset     (reset),
        .wr_valid  (rsp_take),
        .wr_sel    (sel_q),
        .wr_addr   (wbase_q + c0_rsp_mdata),
        .wr_data   (c0_rsp_data),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata)
    );

    assign op_done     = op_done_q;
    assign c0_tx_valid = tx_valid_q;
    assign c0_tx_addr  = tx_addr_q;
    assign c0_tx_mdata = tx_mdata_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_glm_load.sv
// ---------------------------------------------------------------------------
// tb_glm_load: self-checking bench for glm_load.
// ---------------------------------------------------------------------------
module tb_glm_load;
    import glm_common::*;

    localparam int NCH = 2;
`ifdef GLM_LOAD_LIMIT_EN
    localparam int MAX_OUT = 2;
`else
    localparam int MAX_OUT = 64;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              reset;
    logic              op_start;
    logic              op_done;
    logic [31:0]       regs [LOAD_NUM_REGS];
    logic [41:0]       in_addr, out_addr;
    logic              c0TxAlmFull;
    logic              c0_tx_valid;
    logic [41:0]       c0_tx_addr;
    logic [15:0]       c0_tx_mdata;
    logic              c0_rsp_valid;
    logic [15:0]       c0_rsp_mdata;
    logic [511:0]      c0_rsp_data;
    logic [NCH-1:0]    mem_we;
    logic [15:0]       mem_waddr;
    logic [511:0]      mem_wdata;
    t_loadstate        dbg_state;

    always #5 clk = ~clk;

    glm_load #(
        .NUM_CHANNELS    (NCH),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .op_start     (op_start),
        .op_done      (op_done),
        .regs         (regs),
        .in_addr      (in_addr),
        .out_addr     (out_addr),
        .c0TxAlmFull  (c0TxAlmFull),
        .c0_tx_valid  (c0_tx_valid),
        .c0_tx_addr   (c0_tx_addr),
        .c0_tx_mdata  (c0_tx_mdata),
        .c0_rsp_valid (c0_rsp_valid),
        .c0_rsp_mdata (c0_rsp_mdata),
        .c0_rsp_data  (c0_rsp_data),
        .mem_we       (mem_we),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .dbg_state    (dbg_state)
    );

    // ---------------- reference model state ----------------
    int            checks = 0;
    int            errors = 0;
    logic [41:0]   cur_base;
    int            cur_len;
    int            cur_sel;
    int            issued_cnt [0:255];
    int            tx_total = 0;
    int            done_cnt = 0;
    int            we_cnt = 0;
    int            op_tx0, op_done0;
    int            pend_q[$];
    int            fixed_order[$];
    logic [527:0]  exp_q[$];   // {bram address, line data}
    logic [527:0]  mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always begin
        @(posedge clk);
        #1;
        if (c0_tx_valid === 1'b1) begin
            tx_total++;
            chk("tx_addr", 64'(c0_tx_addr), 64'(42'(cur_base + 42'(c0_tx_mdata))));
            chk("tx_during_almfull", 64'(c0TxAlmFull), 64'(0));
            checks++;
            if (int'(c0_tx_mdata) >= cur_len || cur_len > 256) begin
                errors++;
                $display("FAIL tx_tag_range: tag %0d length %0d", c0_tx_mdata, cur_len);
            end else begin
                checks++;
                if (issued_cnt[int'(c0_tx_mdata)] != 0) begin
                    errors++;
                    $display("FAIL tx_tag_dup: tag %0d issued %0d times before", c0_tx_mdata,
                             issued_cnt[int'(c0_tx_mdata)]);
                end
                issued_cnt[int'(c0_tx_mdata)]++;
            end
            pend_q.push_back(int'(c0_tx_mdata));
        end
        if ((|mem_we) === 1'b1) begin
            we_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_we: mem_we %b addr %0h expected no write", mem_we, mem_waddr);
            end else begin
                mon_e = exp_q.pop_front();
                chk("we_onehot", 64'(mem_we), 64'(NCH'(1) << cur_sel));
                chk("waddr", 64'(mem_waddr), 64'(mon_e[527:512]));
                checks++;
                if (mem_wdata !== mon_e[511:0]) begin
                    errors++;
                    $display("FAIL wdata: addr %0h got %0h expected %0h", mem_waddr,
                             mem_wdata[63:0], mon_e[63:0]);
                end
            end
        end
        if (op_done === 1'b1) done_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic drive_rsp(input int tag, input bit expect_wr, input logic [15:0] wb);
        logic [511:0] d;
        for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom();
        c0_rsp_valid = 1'b1;
        c0_rsp_mdata = 16'(tag);
        c0_rsp_data  = d;
        if (expect_wr) exp_q.push_back({16'(wb + 16'(tag)), d});
    endtask

    task automatic start_op(input logic [31:0] ar, input logic [31:0] o0, input logic [31:0] o1,
                            input logic [31:0] o2, input logic [15:0] len, input logic [3:0] sel,
                            input logic [15:0] wb, input logic [41:0] ia, input logic [41:0] oa,
                            input logic [41:0] eb);
        @(negedge clk);
        cur_base = eb;
        cur_len  = int'(len);
        cur_sel  = int'(sel);
        for (int i = 0; i < 256; i++) issued_cnt[i] = 0;
        pend_q.delete();
        op_tx0   = tx_total;
        op_done0 = done_cnt;
        regs[LOAD_REG_OFFSET0] = o0;
        regs[LOAD_REG_OFFSET1] = o1;
        regs[LOAD_REG_OFFSET2] = o2;
        regs[LOAD_REG_ADDR]    = ar;
        regs[LOAD_REG_LEN]     = {16'($urandom()), len};
        regs[LOAD_REG_SEL]     = {28'($urandom()), sel};
        regs[LOAD_REG_WBASE]   = {16'($urandom()), wb};
        in_addr  = ia;
        out_addr = oa;
        op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
    endtask

    // Called at the negedge where the final response is being driven.
    task automatic finish_op();
        @(posedge clk);
        #1;
        chk("state_done", 64'(dbg_state), 64'(LS_DONE));
        chk("done_early", 64'(op_done), 64'(0));
        op_start     = 1'b0;
        c0_rsp_valid = 1'b0;
        c0TxAlmFull  = 1'b0;
        @(posedge clk);
        #1;
        chk("op_done", 64'(op_done), 64'(1));
        chk("state_idle", 64'(dbg_state), 64'(LS_IDLE));
        repeat (3) @(posedge clk);
        #1;
        chk("done_count", 64'(done_cnt - op_done0), 64'(1));
        chk("exp_q_empty", 64'(exp_q.size()), 64'(0));
        for (int i = 0; i < cur_len; i++) chk("tag_once", 64'(issued_cnt[i]), 64'(1));
    endtask

    // mode 0: respond in issue order as soon as possible
    // mode 1: random response timing/order, random back-pressure and stray op_start
    // mode 2: wait for all issues, then respond in fixed_order
    task automatic run_op(input logic [31:0] ar, input logic [31:0] o0, input logic [31:0] o1,
                          input logic [31:0] o2, input logic [15:0] len, input logic [3:0] sel,
                          input logic [15:0] wb, input logic [41:0] ia, input logic [41:0] oa,
                          input logic [41:0] eb, input int mode, input int stall_after);
        int  sent_r = 0;
        int  cyc = 0;
        int  stall_cnt = 0;
        int  idx, tag;
        bit  wr_ok;
        wr_ok = (int'(sel) < NCH);
        start_op(ar, o0, o1, o2, len, sel, wb, ia, oa, eb);
        forever begin
            c0_rsp_valid = 1'b0;
            if (stall_after > 0) begin
                if ((tx_total - op_tx0) >= stall_after && stall_cnt < 5) begin
                    c0TxAlmFull = 1'b1;
                    stall_cnt++;
                end else begin
                    c0TxAlmFull = 1'b0;
                end
            end else if (mode == 1) begin
                c0TxAlmFull = ($urandom_range(0, 3) == 0);
                op_start    = ($urandom_range(0, 7) == 0);
            end
            if (mode == 2) begin
                if ((tx_total - op_tx0) == int'(len) && fixed_order.size() > 0) begin
                    tag = fixed_order.pop_front();
                    drive_rsp(tag, wr_ok, wb);
                    sent_r++;
                end
            end else if (pend_q.size() > 0 && (mode == 0 || $urandom_range(0, 1) == 1)) begin
                idx = (mode == 1) ? $urandom_range(0, pend_q.size() - 1) : 0;
                tag = pend_q[idx];
                pend_q.delete(idx);
                drive_rsp(tag, wr_ok, wb);
                sent_r++;
            end
            if (sent_r == int'(len)) break;
            if (cyc >= 2000) begin
                checks++;
                errors++;
                $display("FAIL op_timeout: %0d of %0d responses after %0d cycles", sent_r, len, cyc);
                c0_rsp_valid = 1'b0;
                c0TxAlmFull  = 1'b0;
                op_start     = 1'b0;
                return;
            end
            @(negedge clk);
            cyc++;
        end
        finish_op();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] addr_reg;
        logic [31:0] off0, off1, off2;
        logic [15:0] len;
        logic [3:0]  sel;
        logic [15:0] wbase;
        logic [41:0] ia, oa;
        logic [41:0] exp_base;
        int          mode;
        int          stall_after;
    } vec_t;

    vec_t vecs[6];

    // ---------------- main sequence ----------------
    initial begin
        int          exp_n, tag, cyc, we0, d0, t0;
        logic [31:0] ar, o0, o1, o2;
        logic [41:0] ia, oa, eb;

        reset        = 1'b1;
        op_start     = 1'b0;
        c0TxAlmFull  = 1'b0;
        c0_rsp_valid = 1'b0;
        c0_rsp_mdata = '0;
        c0_rsp_data  = '0;
        in_addr      = '0;
        out_addr     = '0;
        for (int i = 0; i < LOAD_NUM_REGS; i++) regs[i] = '0;
        cur_base = '0;
        cur_len  = 0;
        cur_sel  = 0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_op_done", 64'(op_done), 64'(0));
        chk("rst_tx_valid", 64'(c0_tx_valid), 64'(0));
        chk("rst_tx_addr", 64'(c0_tx_addr), 64'(0));
        chk("rst_tx_mdata", 64'(c0_tx_mdata), 64'(0));
        chk("rst_mem_we", 64'(mem_we), 64'(0));
        chk("rst_mem_waddr", 64'(mem_waddr), 64'(0));
        chk("rst_mem_wdata", 64'(|mem_wdata), 64'(0));
        chk("rst_state", 64'(dbg_state), 64'(LS_IDLE));
        @(negedge clk);
        reset = 1'b0;

        vecs[0] = '{32'h10, 32'd1, 32'd2, 32'd3, 16'd4, 4'd0, 16'h0,
                    42'h0, 42'h1000, 42'h1016, 0, 0};
        vecs[1] = '{32'h10, 32'd1, 32'd2, 32'd3, 16'd4, 4'd0, 16'h0,
                    42'h0, 42'h1000, 42'h1016, 2, 0};
        vecs[2] = '{32'h8000_0020, 32'h100, 32'h0, 32'h5, 16'd5, 4'd1, 16'h40,
                    42'h2000, 42'h1000, 42'h2125, 1, 0};
        vecs[3] = '{32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 16'd3, 4'd7, 16'h0,
                    42'h0, 42'h3_0000_0000, 42'h4_0000_0000, 1, 0};
        vecs[4] = '{32'h8000_0000, 32'h0, 32'h0, 32'h0, 16'd4, 4'd0, 16'hFFFE,
                    42'h3FF_FFFF_FFFE, 42'h0, 42'h3FF_FFFF_FFFE, 0, 0};
        vecs[5] = '{32'h4, 32'h0, 32'h0, 32'h0, 16'd8, 4'd1, 16'h100,
                    42'h0, 42'h500, 42'h504, 0, 2};

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].mode == 2) fixed_order = '{3, 1, 0, 2};
            run_op(vecs[v].addr_reg, vecs[v].off0, vecs[v].off1, vecs[v].off2, vecs[v].len,
                   vecs[v].sel, vecs[v].wbase, vecs[v].ia, vecs[v].oa, vecs[v].exp_base,
                   vecs[v].mode, vecs[v].stall_after);
        end

        // length 0: op_done two cycles after op_start, no traffic
        @(negedge clk);
        cur_len  = 0;
        op_tx0   = tx_total;
        op_done0 = done_cnt;
        we0      = we_cnt;
        regs[LOAD_REG_LEN] = 32'hFFFF_0000;
        regs[LOAD_REG_SEL] = 32'h0;
        op_start = 1'b1;
        @(posedge clk);
        #1;
        op_start = 1'b0;
        chk("len0_state", 64'(dbg_state), 64'(LS_DONE));
        chk("len0_done_early", 64'(op_done), 64'(0));
        @(posedge clk);
        #1;
        chk("len0_done", 64'(op_done), 64'(1));
        @(posedge clk);
        #1;
        chk("len0_done_pulse", 64'(op_done), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("len0_no_tx", 64'(tx_total - op_tx0), 64'(0));
        chk("len0_no_we", 64'(we_cnt - we0), 64'(0));
        chk("len0_done_count", 64'(done_cnt - op_done0), 64'(1));

        // outstanding cap: issued = min(len, cap + responses)
        start_op(32'h0, 32'h0, 32'h0, 32'h0, 16'd6, 4'd0, 16'h20, 42'h0, 42'h800, 42'h800);
        repeat (30) @(negedge clk);
        exp_n = (6 < MAX_OUT) ? 6 : MAX_OUT;
        chk("limit_initial", 64'(tx_total - op_tx0), 64'(exp_n));
        for (int r = 1; r <= 6; r++) begin
            if (pend_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL limit_starved: no issued tag available for response %0d", r);
                break;
            end
            tag = pend_q.pop_front();
            drive_rsp(tag, 1'b1, 16'h20);
            if (r == 6) begin
                finish_op();
                break;
            end
            @(negedge clk);
            c0_rsp_valid = 1'b0;
            repeat (10) @(negedge clk);
            exp_n = (6 < MAX_OUT + r) ? 6 : MAX_OUT + r;
            chk("limit_release", 64'(tx_total - op_tx0), 64'(exp_n));
        end
        c0_rsp_valid = 1'b0;

        // reset after 3 of 8 requests, then late responses
        start_op(32'h0, 32'h0, 32'h0, 32'h0, 16'd8, 4'd0, 16'h0, 42'h0, 42'h9000, 42'h9000);
        cyc = 0;
        while ((tx_total - op_tx0) < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_mid_tx", 64'(tx_total - op_tx0), 64'(3));
        c0TxAlmFull = 1'b1;
        reset       = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_state", 64'(dbg_state), 64'(LS_IDLE));
        chk("rst_mid_tx_valid", 64'(c0_tx_valid), 64'(0));
        chk("rst_mid_tx_addr", 64'(c0_tx_addr), 64'(0));
        chk("rst_mid_tx_mdata", 64'(c0_tx_mdata), 64'(0));
        chk("rst_mid_op_done", 64'(op_done), 64'(0));
        @(negedge clk);
        reset       = 1'b0;
        c0TxAlmFull = 1'b0;
        we0 = we_cnt;
        d0  = done_cnt;
        t0  = tx_total;
        while (pend_q.size() > 0) begin
            drive_rsp(pend_q.pop_front(), 1'b0, 16'h0);
            @(negedge clk);
            c0_rsp_valid = 1'b0;
        end
        repeat (4) @(negedge clk);
        chk("rst_late_no_we", 64'(we_cnt - we0), 64'(0));
        chk("rst_late_idle", 64'(dbg_state), 64'(LS_IDLE));
        chk("rst_late_no_done", 64'(done_cnt - d0), 64'(0));
        chk("rst_late_no_tx", 64'(tx_total - t0), 64'(0));
        run_op(vecs[0].addr_reg, vecs[0].off0, vecs[0].off1, vecs[0].off2, vecs[0].len,
               vecs[0].sel, vecs[0].wbase, vecs[0].ia, vecs[0].oa, vecs[0].exp_base, 0, 0);

        // randomized operations against the address-arithmetic model
        for (int n = 0; n < 15; n++) begin
            ar = $urandom();
            o0 = $urandom();
            o1 = $urandom();
            o2 = $urandom();
            ia = {10'($urandom_range(0, 1023)), 32'($urandom())};
            oa = {10'($urandom_range(0, 1023)), 32'($urandom())};
            eb = (ar[31] ? ia : oa) + 42'(ar[30:0]) + 42'(o0) + 42'(o1) + 42'(o2);
            run_op(ar, o0, o1, o2, 16'($urandom_range(1, 10)), 4'($urandom_range(0, 3)),
                   16'($urandom_range(0, 65535)), ia, oa, eb, 1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
